// File: rtl/phy_link_if.sv
// Lane control/status bundle between the link controller and its user.
// The master side drives the lane enable, the PHY/PCS status inputs and the
// retry clear. The slave side (the controller) returns reset, link and state.
interface phy_link_if;
    logic       enable;
    logic       qpll_lock;
    logic       rx_block_lock;
    logic       rx_high_ber;
    logic       retry_clear;
    logic       phy_rst;
    logic       link_up;
    logic [7:0] retry_count;
    logic [2:0] state;

    modport master (
        output enable,
        output qpll_lock,
        output rx_block_lock,
        output rx_high_ber,
        output retry_clear,
        input  phy_rst,
        input  link_up,
        input  retry_count,
        input  state
    );

    modport slave (
        input  enable,
        input  qpll_lock,
        input  rx_block_lock,
        input  rx_high_ber,
        input  retry_clear,
        output phy_rst,
        output link_up,
        output retry_count,
        output state
    );
endinterface

// File: rtl/phy_link_ctrl.sv
// Transceiver lane bring-up controller.
// Sequence: hold the PHY in reset, wait for QPLL lock, then wait for PCS block
// lock with a clean BER. Link-up is reported only after a debounce window of
// consecutive good cycles. Any loss of lock, timeout or link drop restarts
// from RESET and bumps a saturating retry counter.
module phy_link_ctrl #(
    parameter int RST_HOLD     = 64,
    parameter int LOCK_TIMEOUT = 1048576,
    parameter int UP_DEBOUNCE  = 1024
) (
    input  logic       clk,
    input  logic       rst,
    phy_link_if.slave  bus
);

    localparam int MAX_AB  = (RST_HOLD > LOCK_TIMEOUT) ? RST_HOLD : LOCK_TIMEOUT;
    localparam int MAX_CYC = (MAX_AB > UP_DEBOUNCE) ? MAX_AB : UP_DEBOUNCE;
    localparam int TIMER_W = $clog2(MAX_CYC) + 1;

    // The timer counts down to zero, so each load value is the duration minus one.
    localparam logic [TIMER_W-1:0] RST_LOAD  = TIMER_W'(RST_HOLD - 1);
    localparam logic [TIMER_W-1:0] LOCK_LOAD = TIMER_W'(LOCK_TIMEOUT - 1);
    localparam logic [TIMER_W-1:0] DEB_LOAD  = TIMER_W'(UP_DEBOUNCE - 1);
    localparam logic [TIMER_W-1:0] TIMER_ONE = TIMER_W'(1);

    typedef enum logic [2:0] {
        ST_DISABLED  = 3'd0,
        ST_RESET     = 3'd1,
        ST_WAIT_PLL  = 3'd2,
        ST_WAIT_LOCK = 3'd3,
        ST_DEBOUNCE  = 3'd4,
        ST_UP        = 3'd5
    } state_t;

    state_t             state_reg;
    state_t             state_next;
    logic [TIMER_W-1:0] timer_reg;
    logic [TIMER_W-1:0] timer_next;
    logic [7:0]         retry_count_reg;
    logic               retry_pulse;
    logic               good;
    logic               timer_zero;

    assign good       = bus.qpll_lock & bus.rx_block_lock & ~bus.rx_high_ber;
    assign timer_zero = (timer_reg == '0);

    // State and cycle timer registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg <= ST_DISABLED;
            timer_reg <= '0;
        end else begin
            state_reg <= state_next;
            timer_reg <= timer_next;
        end
    end

    // Next-state, timer and retry decode; lane disable overrides everything.
    always_comb begin
        state_next  = state_reg;
        timer_next  = timer_reg;
        retry_pulse = 1'b0;

        if (!bus.enable) begin
            state_next = ST_DISABLED;
            timer_next = '0;
        end else begin
            case (state_reg)
                ST_DISABLED: begin
                    state_next = ST_RESET;
                    timer_next = RST_LOAD;
                end

                ST_RESET: begin
                    if (timer_zero) begin
                        state_next = ST_WAIT_PLL;
                        timer_next = LOCK_LOAD;
                    end else begin
                        timer_next = timer_reg - TIMER_ONE;
                    end
                end

                ST_WAIT_PLL: begin
                    if (bus.qpll_lock) begin
                        state_next = ST_WAIT_LOCK;
                        timer_next = LOCK_LOAD;
                    end else if (timer_zero) begin
                        state_next  = ST_RESET;
                        timer_next  = RST_LOAD;
                        retry_pulse = 1'b1;
                    end else begin
                        timer_next = timer_reg - TIMER_ONE;
                    end
                end

                ST_WAIT_LOCK: begin
                    if (!bus.qpll_lock || (!good && timer_zero)) begin
                        state_next  = ST_RESET;
                        timer_next  = RST_LOAD;
                        retry_pulse = 1'b1;
                    end else if (good) begin
                        state_next = ST_DEBOUNCE;
                        timer_next = DEB_LOAD;
                    end else begin
                        timer_next = timer_reg - TIMER_ONE;
                    end
                end

                ST_DEBOUNCE: begin
                    // A glitch only restarts the lock wait; it is not a retry.
                    if (!good) begin
                        state_next = ST_WAIT_LOCK;
                        timer_next = LOCK_LOAD;
                    end else if (timer_zero) begin
                        state_next = ST_UP;
                    end else begin
                        timer_next = timer_reg - TIMER_ONE;
                    end
                end

                ST_UP: begin
                    if (!good) begin
                        state_next  = ST_RESET;
                        timer_next  = RST_LOAD;
                        retry_pulse = 1'b1;
                    end
                end

                default: begin
                    state_next = ST_DISABLED;
                    timer_next = '0;
                end
            endcase
        end
    end

    // Saturating retry counter; a clear beats a coincident retry.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            retry_count_reg <= '0;
        end else if (bus.retry_clear) begin
            retry_count_reg <= '0;
        end else if (retry_pulse && (retry_count_reg != 8'hFF)) begin
            retry_count_reg <= retry_count_reg + 8'd1;
        end
    end

    assign bus.phy_rst     = (state_reg == ST_DISABLED) || (state_reg == ST_RESET);
    assign bus.link_up     = (state_reg == ST_UP);
    assign bus.retry_count = retry_count_reg;
    assign bus.state       = state_reg;

endmodule

// File: doc/phy_link_ctrl.md
PHY_LINK_CTRL -- requirements
Module: phy_link_ctrl

Interface
REQ-001 Parameter RST_HOLD, default 64: number of cycles phy_rst is held in the RESET state (minimum 1).
REQ-002 Parameter LOCK_TIMEOUT, default 1048576: maximum cycles spent in WAIT_PLL or WAIT_LOCK before a retry (minimum 2).
REQ-003 Parameter UP_DEBOUNCE, default 1024: number of consecutive good cycles required before link up (minimum 1).
REQ-004 clk  input  1  single clock; all logic on the rising edge.
REQ-005 rst  input  1  reset, asynchronous, active-high.
REQ-006 enable  input  1  lane enable; when 0, the lane is held in reset.
REQ-007 qpll_lock  input  1  QPLL lock from the transceiver common block, synchronous to clk.
REQ-008 rx_block_lock  input  1  PCS receive block lock, synchronous to clk.
REQ-009 rx_high_ber  input  1  PCS high-BER indication, synchronous to clk.
REQ-010 retry_clear  input  1  single-cycle pulse that zeroes retry_count.
REQ-011 phy_rst  output  1  transceiver/PCS reset request.
REQ-012 link_up  output  1  qualified link status.
REQ-013 retry_count  output  8  saturating count of retries.
REQ-014 state  output  3  current state encoding.

Function
REQ-015 There SHALL be six states with these encodings: DISABLED=0, RESET=1, WAIT_PLL=2, WAIT_LOCK=3, DEBOUNCE=4, UP=5; codes 6 and 7 SHALL go to DISABLED on the next edge.
REQ-016 Outputs SHALL be decoded from the state register only:
- phy_rst = (state==DISABLED || state==RESET)
- link_up = (state==UP)
REQ-017 A "good" condition SHALL be defined as qpll_lock & rx_block_lock & ~rx_high_ber.
REQ-018 From any state, enable==0 sampled at an edge SHALL give state DISABLED after that edge; this takes priority over all other transitions.
REQ-019 DISABLED with enable==1 SHALL go to RESET, and the cycle timer SHALL be loaded.
REQ-020 RESET SHALL last exactly RST_HOLD cycles, then go to WAIT_PLL.
REQ-021 WAIT_PLL transitions:
- qpll_lock==1 goes to WAIT_LOCK with the timer reloaded.
- After LOCK_TIMEOUT cycles without qpll_lock, go to RESET and perform a retry.
REQ-022 WAIT_LOCK transitions:
- good goes to DEBOUNCE.
- qpll_lock==0 goes to RESET with a retry.
- After LOCK_TIMEOUT cycles without good, go to RESET with a retry.
REQ-023 DEBOUNCE transitions:
- After UP_DEBOUNCE consecutive good cycles (counting the cycles spent in DEBOUNCE), go to UP.
- Any non-good cycle goes to WAIT_LOCK with the timer reloaded; no retry is counted.
REQ-024 UP SHALL hold while good, and SHALL go to RESET with a retry on the first non-good cycle.
REQ-025 A retry SHALL increment retry_count by 1, saturating at 255.
REQ-026 retry_clear SHALL zero retry_count on the next edge; when a clear and a retry occur in the same cycle, the clear wins (result 0).
REQ-027 The timer width SHALL be $clog2 of the largest of RST_HOLD, LOCK_TIMEOUT and UP_DEBOUNCE, plus 1; the timer SHALL never wrap.
REQ-028 Inputs SHALL be used directly, with no internal synchronizers, and outputs SHALL have no combinational path from inputs.

Reset
REQ-029 While rst is high, and after it is released, the block SHALL hold:
- state = DISABLED, phy_rst = 1, link_up = 0, retry_count = 0, timer = 0.
REQ-030 rst asserted mid-operation SHALL return all registers to the REQ-029 values asynchronously; operation resumes from DISABLED on the first edge after release.

Verification
Parameters for all scenarios: RST_HOLD=4, LOCK_TIMEOUT=32, UP_DEBOUNCE=8.
REQ-031 Clean bring-up: enable=1, qpll_lock=1, rx_block_lock=1, rx_high_ber=0 from cycle 0 -> phy_rst is high for exactly 4 cycles in RESET; link_up rises after 1+4+1+1+8 edges; retry_count stays 0.
REQ-032 PLL timeout: qpll_lock held 0 -> after 32 cycles in WAIT_PLL the state returns to RESET, retry_count=1; after 3 repeats, retry_count=3.
REQ-033 Debounce glitch: rx_block_lock drops for 1 cycle during DEBOUNCE cycle 5 -> state goes to WAIT_LOCK with no retry; 8 further good cycles are needed before UP.
REQ-034 Link loss: rx_high_ber=1 for 1 cycle in UP -> link_up=0 and phy_rst=1 on the next edge; retry_count increments.
REQ-035 Saturation/clear: force 300 retries -> retry_count=255; retry_clear coincident with a retry -> retry_count=0.
REQ-036 Disable/reset mid-op: enable=0 in WAIT_LOCK -> DISABLED on the next edge; async rst pulse in UP -> outputs return to reset values immediately without waiting for a clock edge.
